pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Central hazard and redirect scheduler for the 5-stage MIPS pipeline.
- Resolves branches, jumps and overflow exceptions from the EX/MEM stage outputs.
- Detects load-use hazards between ID and EX, and freezes the pipeline while data memory is not ready.
- Drives per-stage stall/flush enables for the IF/ID, ID/EX and EX/MEM registers, plus the next-PC select.
- Clocked on negedge clk, like the pipeline registers it controls.

Parameters:
- EXC_VECTOR, 32'h0000_0180, exception handler address presented on pc_target.
- EXC_DRAIN, 2, cycles the pipeline stays flushed after an exception (1..15).
- MEM_TIMEOUT, 15, data-memory wait cycles before bus_err is raised (1..255).

Ports:
- clk  in  1  clock; state updates on the negative edge.
- Reset  in  1  synchronous, active-high.
- Jump_mem  in  1  jump in MEM stage.
- Condition_mem  in  3  branch condition code of the MEM-stage instruction.
- Less_mem, Zero_mem, Overflow_mem  in  1 each  ALU flags from EX/MEM.
- RegWr_mem, MemWr_mem, MemtoReg_mem  in  1 each  MEM-stage controls.
- PC_Branch_mem, PC_Jump_mem, pc_mem  in  32 each  branch target, jump target, PC of the MEM-stage instruction.
- MemtoReg_ex  in  1  EX-stage instruction is a load.
- Rd_ex  in  5  EX-stage destination register.
- rs_id, rt_id  in  5 each  ID-stage source registers.
- dmem_ready  in  1  data memory completes this cycle.
- pc_sel  out  2  0 = sequential, 1 = branch, 2 = jump, 3 = exception.
- pc_target  out  32  selected redirect address.
- stall_if, stall_id  out  1 each  hold PC / hold IF/ID.
- flush_id, flush_ex, flush_mem  out  1 each  insert bubble into IF/ID, ID/EX, EX/MEM.
- kill_wb  out  1  suppress RegWr of the MEM-stage instruction.
- epc  out  32  captured exception PC.
- bus_err  out  1  sticky memory timeout flag.

Behaviour:
- Condition codes:
  - 0: none.
  - 1: beq, taken when Zero.
  - 2: bne, taken when !Zero.
  - 3: blez, taken when Less|Zero.
  - 4: bgtz, taken when !Less&!Zero.
  - 5: bltz, taken when Less.
  - 6: bgez, taken when !Less.
  - 7: reserved, never taken.
- States: RUN, MEMWAIT, EXC.
- Reset: state RUN; epc = 0; bus_err = 0; counters = 0. All outputs read 0 (pc_sel = 0, pc_target = 0).
- Outputs are combinational from state and inputs; only state, counters, epc and bus_err are registered.
- mem_req = MemWr_mem | MemtoReg_mem.
- RUN, evaluated in priority order:
  1. mem_req & !dmem_ready: assert stall_if, stall_id, and hold ID/EX and EX/MEM via flush_* = 0 with stall asserted. Go to MEMWAIT, wait counter = 1. No redirect is taken this cycle.
  2. Overflow_mem & RegWr_mem: pc_sel = 3, pc_target = EXC_VECTOR, kill_wb = 1, flush_id = flush_ex = flush_mem = 1. epc <= pc_mem. Go to EXC, drain counter = EXC_DRAIN.
  3. Jump_mem: pc_sel = 2, pc_target = PC_Jump_mem, flush all three.
  4. Branch taken: pc_sel = 1, pc_target = PC_Branch_mem, flush all three.
  5. Load-use: MemtoReg_ex & Rd_ex != 0 & (Rd_ex == rs_id | Rd_ex == rt_id). Assert stall_if, stall_id, flush_ex for exactly one cycle.
  6. Otherwise all outputs 0.
- MEMWAIT:
  - stall_if and stall_id stay asserted; EX/MEM is held.
  - On dmem_ready: return to RUN. The RUN rules are evaluated in that same cycle, so a pending redirect is taken then.
  - On the cycle the wait counter reaches MEM_TIMEOUT: set bus_err, then force a return to RUN and treat the access as complete.
  - The wait counter saturates and does not wrap.
- EXC:
  - flush_id = flush_ex = flush_mem = 1 and pc_sel = 0 for each cycle while the counter is nonzero; the counter decrements.
  - Overflow, branch and jump inputs are ignored.
  - Return to RUN when the counter reaches 0.
  - EXC_DRAIN = 1 gives exactly one extra flush cycle.
- bus_err clears only on Reset.
- Reset asserted in any state returns to RUN on that edge; any redirect in progress is discarded.
- Simultaneous overflow and load-use: the exception wins and no stall is issued.

Decomposition:
- Package pipe_ctrl_pkg holds:
  - Condition code constants COND_NONE..COND_BGEZ.
  - pc_sel encodings PCSEL_SEQ, PCSEL_BR, PCSEL_J, PCSEL_EXC.
  - The state enum.
- One natural sub-module, branch_cond_eval: combinational taken = f(Condition, Less, Zero), reused by the verification model.

Test Plan:
- Condition = 1, Zero = 1, PC_Branch_mem = 0x40 -> pc_sel = 1, pc_target = 0x40, all flushes = 1 for one cycle. Repeat with Condition = 7 -> no redirect.
- MemtoReg_ex = 1, Rd_ex = 5, rt_id = 5 -> exactly one cycle of stall_if/stall_id/flush_ex. With Rd_ex = 0 -> no stall.
- Overflow_mem = 1, RegWr_mem = 1, pc_mem = 0x1234, EXC_DRAIN = 2:
  - First cycle: pc_sel = 3, pc_target = 0x180, kill_wb = 1.
  - epc = 0x1234.
  - Two further flush-only cycles, during which a branch is ignored.
- MemtoReg_mem = 1 with dmem_ready low for 3 cycles while Jump_mem = 1 -> stalls held for 3 cycles, no redirect; jump is taken on the dmem_ready cycle.
- dmem_ready never asserted, MEM_TIMEOUT = 15 -> bus_err rises on wait cycle 15, state returns to RUN, bus_err stays set until Reset.
- Reset asserted mid-EXC -> next cycle state RUN, epc = 0, all outputs 0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline hazard/redirect controller: branch condition
// codes, next-PC select values and the controller state enum.
package pipe_ctrl_pkg;

  localparam logic [2:0] COND_NONE = 3'd0;
  localparam logic [2:0] COND_BEQ  = 3'd1;
  localparam logic [2:0] COND_BNE  = 3'd2;
  localparam logic [2:0] COND_BLEZ = 3'd3;
  localparam logic [2:0] COND_BGTZ = 3'd4;
  localparam logic [2:0] COND_BLTZ = 3'd5;
  localparam logic [2:0] COND_BGEZ = 3'd6;

  localparam logic [1:0] PCSEL_SEQ = 2'd0;
  localparam logic [1:0] PCSEL_BR  = 2'd1;
  localparam logic [1:0] PCSEL_J   = 2'd2;
  localparam logic [1:0] PCSEL_EXC = 2'd3;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_MEMWAIT = 2'd1,
    ST_EXC     = 2'd2
  } state_t;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Signals between the 5-stage pipeline datapath (master) and the hazard
// controller (slave).
interface pipe_hazard_ctrl_if;
  logic        Jump_mem;
  logic [2:0]  Condition_mem;
  logic        Less_mem, Zero_mem, Overflow_mem;
  logic        RegWr_mem, MemWr_mem, MemtoReg_mem;
  logic [31:0] PC_Branch_mem, PC_Jump_mem, pc_mem;
  logic        MemtoReg_ex;
  logic [4:0]  Rd_ex, rs_id, rt_id;
  logic        dmem_ready;
  logic [1:0]  pc_sel;
  logic [31:0] pc_target;
  logic        stall_if, stall_id, flush_id, flush_ex, flush_mem, kill_wb;
  logic [31:0] epc;
  logic        bus_err;

  modport master (
    output Jump_mem, Condition_mem, Less_mem, Zero_mem, Overflow_mem,
           RegWr_mem, MemWr_mem, MemtoReg_mem, PC_Branch_mem, PC_Jump_mem, pc_mem,
           MemtoReg_ex, Rd_ex, rs_id, rt_id, dmem_ready,
    input  pc_sel, pc_target, stall_if, stall_id, flush_id, flush_ex, flush_mem,
           kill_wb, epc, bus_err
  );

  modport slave (
    input  Jump_mem, Condition_mem, Less_mem, Zero_mem, Overflow_mem,
           RegWr_mem, MemWr_mem, MemtoReg_mem, PC_Branch_mem, PC_Jump_mem, pc_mem,
           MemtoReg_ex, Rd_ex, rs_id, rt_id, dmem_ready,
    output pc_sel, pc_target, stall_if, stall_id, flush_id, flush_ex, flush_mem,
           kill_wb, epc, bus_err
  );
endinterface

// File: rtl/branch_cond_eval.sv
// Branch-taken decision from the MEM-stage condition code and ALU flags.
module branch_cond_eval
  import pipe_ctrl_pkg::*;
(
  input  logic [2:0] cond,
  input  logic       less,
  input  logic       zero,
  output logic       taken
);

  always_comb begin
    taken = 1'b0;
    case (cond)
      COND_BEQ:  taken = zero;
      COND_BNE:  taken = !zero;
      COND_BLEZ: taken = less | zero;
      COND_BGTZ: taken = !less & !zero;
      COND_BLTZ: taken = less;
      COND_BGEZ: taken = !less;
      default:   taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and redirect scheduler for the 5-stage pipeline: memory freeze, exceptions,
// jumps/branches and load-use stalls. State updates on the falling clock edge.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR  = 32'h0000_0180,
  parameter int          EXC_DRAIN   = 2,
  parameter int          MEM_TIMEOUT = 15
) (
  input logic               clk,
  input logic               Reset,
  pipe_hazard_ctrl_if.slave bus
);

  localparam logic [7:0] TMO   = 8'(MEM_TIMEOUT);
  localparam logic [3:0] DRAIN = 4'(EXC_DRAIN);

  state_t      state, next_state;
  logic [7:0]  wait_cnt, wait_next;
  logic [3:0]  drain_cnt, drain_next;
  logic [31:0] epc_q;
  logic        err_q, set_err, epc_load;

  logic        taken, mem_req, load_use, timeout, run_eval, mem_busy;
  logic [1:0]  sel_c;
  logic [31:0] tgt_c;
  logic        sif_c, sid_c, fid_c, fex_c, fmem_c, kill_c;

  branch_cond_eval u_cond (
    .cond  (bus.Condition_mem),
    .less  (bus.Less_mem),
    .zero  (bus.Zero_mem),
    .taken (taken)
  );

  assign mem_req  = bus.MemWr_mem | bus.MemtoReg_mem;
  assign load_use = bus.MemtoReg_ex && (bus.Rd_ex != 5'd0) &&
                    ((bus.Rd_ex == bus.rs_id) || (bus.Rd_ex == bus.rt_id));
  // The counter equals MEM_TIMEOUT after that many stalled cycles; the access is then
  // released as if the memory had answered.
  assign timeout  = (state == ST_MEMWAIT) && (wait_cnt == TMO);

  always_comb begin
    next_state = state;
    wait_next  = wait_cnt;
    drain_next = drain_cnt;
    epc_load   = 1'b0;
    set_err    = 1'b0;
    run_eval   = 1'b0;
    mem_busy   = 1'b0;
    sel_c      = PCSEL_SEQ;
    tgt_c      = 32'd0;
    {sif_c, sid_c, fid_c, fex_c, fmem_c, kill_c} = 6'b0;

    case (state)
      ST_RUN: begin
        run_eval = 1'b1;
        mem_busy = mem_req & !bus.dmem_ready;
      end
      ST_MEMWAIT: begin
        if (bus.dmem_ready || timeout) begin
          run_eval   = 1'b1;
          next_state = ST_RUN;
          set_err    = timeout & !bus.dmem_ready;
        end else begin
          sif_c     = 1'b1;
          sid_c     = 1'b1;
          wait_next = (wait_cnt == 8'hFF) ? wait_cnt : wait_cnt + 8'd1;
        end
      end
      ST_EXC: begin
        if (drain_cnt != 4'd0) begin
          {fid_c, fex_c, fmem_c} = 3'b111;
          drain_next = drain_cnt - 4'd1;
          if (drain_cnt == 4'd1) next_state = ST_RUN;
        end else begin
          next_state = ST_RUN;
        end
      end
      default: next_state = ST_RUN;
    endcase

    if (run_eval) begin
      if (mem_busy) begin
        sif_c      = 1'b1;
        sid_c      = 1'b1;
        next_state = ST_MEMWAIT;
        wait_next  = 8'd1;
      end else if (bus.Overflow_mem && bus.RegWr_mem) begin
        sel_c      = PCSEL_EXC;
        tgt_c      = EXC_VECTOR;
        kill_c     = 1'b1;
        {fid_c, fex_c, fmem_c} = 3'b111;
        epc_load   = 1'b1;
        next_state = ST_EXC;
        drain_next = DRAIN;
      end else if (bus.Jump_mem) begin
        sel_c = PCSEL_J;
        tgt_c = bus.PC_Jump_mem;
        {fid_c, fex_c, fmem_c} = 3'b111;
      end else if (taken) begin
        sel_c = PCSEL_BR;
        tgt_c = bus.PC_Branch_mem;
        {fid_c, fex_c, fmem_c} = 3'b111;
      end else if (load_use) begin
        sif_c = 1'b1;
        sid_c = 1'b1;
        fex_c = 1'b1;
      end
    end
  end

  // Outputs are forced quiet while Reset is held so no redirect leaks out.
  assign bus.pc_sel    = Reset ? PCSEL_SEQ : sel_c;
  assign bus.pc_target = Reset ? 32'd0 : tgt_c;
  assign bus.stall_if  = sif_c  & !Reset;
  assign bus.stall_id  = sid_c  & !Reset;
  assign bus.flush_id  = fid_c  & !Reset;
  assign bus.flush_ex  = fex_c  & !Reset;
  assign bus.flush_mem = fmem_c & !Reset;
  assign bus.kill_wb   = kill_c & !Reset;
  assign bus.epc       = epc_q;
  assign bus.bus_err   = err_q;

  always_ff @(negedge clk) begin
    if (Reset) begin
      state     <= ST_RUN;
      wait_cnt  <= 8'd0;
      drain_cnt <= 4'd0;
      epc_q     <= 32'd0;
      err_q     <= 1'b0;
    end else begin
      state     <= next_state;
      wait_cnt  <= wait_next;
      drain_cnt <= drain_next;
      if (epc_load) epc_q <= bus.pc_mem;
      if (set_err)  err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with a cycle-level reference model checked on
// every rising edge (mid-cycle for a negedge design).
module tb_pipe_hazard_ctrl;

  localparam int          TMO   = 15;
  localparam int          DRAIN = 2;
  localparam logic [31:0] VEC   = 32'h0000_0180;
  localparam int M_RUN = 0, M_WAIT = 1, M_EXC = 2;

  logic clk = 1'b0;
  logic Reset;
  int   n_cmp = 0, n_bad = 0;
  bit   chk_en = 1'b0;

  pipe_hazard_ctrl_if bus ();

  pipe_hazard_ctrl #(.EXC_VECTOR(VEC), .EXC_DRAIN(DRAIN), .MEM_TIMEOUT(TMO)) dut (
    .clk   (clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  function automatic bit ref_taken(input int c, input bit l, input bit z);
    case (c)
      1: return z;
      2: return !z;
      3: return l || z;
      4: return !l && !z;
      5: return l;
      6: return !l;
      default: return 1'b0;
    endcase
  endfunction

  // Reference model: current mode, cycles the pending access has stalled, drain cycles left.
  int          m_mode = M_RUN, m_stalled = 0, m_left = 0;
  logic [31:0] m_epc = '0;
  bit          m_err = 1'b0;
  int          p_mode, p_stalled, p_left;
  logic [31:0] p_epc;
  bit          p_err;
  logic [1:0]  e_sel;
  logic [31:0] e_tgt;
  bit          e_sif, e_sid, e_fid, e_fex, e_fmem, e_kill, rules, busy;

  always @(posedge clk) begin
    e_sel = 2'd0; e_tgt = '0;
    {e_sif, e_sid, e_fid, e_fex, e_fmem, e_kill} = '0;
    p_mode = m_mode; p_stalled = m_stalled; p_left = m_left; p_epc = m_epc; p_err = m_err;
    rules = 1'b0;
    busy  = (bus.MemWr_mem || bus.MemtoReg_mem) && !bus.dmem_ready;
    if (m_mode == M_RUN) rules = 1'b1;
    else if (m_mode == M_WAIT) begin
      if (bus.dmem_ready) begin
        rules = 1'b1; p_mode = M_RUN;
      end else if (m_stalled >= TMO) begin
        rules = 1'b1; busy = 1'b0; p_mode = M_RUN; p_err = 1'b1;
      end else begin
        e_sif = 1'b1; e_sid = 1'b1;
        p_stalled = (m_stalled < 255) ? m_stalled + 1 : 255;
      end
    end else begin
      if (m_left > 0) begin
        e_fid = 1'b1; e_fex = 1'b1; e_fmem = 1'b1; p_left = m_left - 1;
      end
      if (p_left == 0) p_mode = M_RUN;
    end
    if (rules) begin
      if (busy) begin
        e_sif = 1'b1; e_sid = 1'b1; p_mode = M_WAIT; p_stalled = 1;
      end else if (bus.Overflow_mem && bus.RegWr_mem) begin
        e_sel = 2'd3; e_tgt = VEC; e_kill = 1'b1;
        e_fid = 1'b1; e_fex = 1'b1; e_fmem = 1'b1;
        p_epc = bus.pc_mem; p_mode = M_EXC; p_left = DRAIN;
      end else if (bus.Jump_mem) begin
        e_sel = 2'd2; e_tgt = bus.PC_Jump_mem; e_fid = 1'b1; e_fex = 1'b1; e_fmem = 1'b1;
      end else if (ref_taken(int'(bus.Condition_mem), bus.Less_mem, bus.Zero_mem)) begin
        e_sel = 2'd1; e_tgt = bus.PC_Branch_mem; e_fid = 1'b1; e_fex = 1'b1; e_fmem = 1'b1;
      end else if (bus.MemtoReg_ex && bus.Rd_ex != 0 &&
                   (bus.Rd_ex == bus.rs_id || bus.Rd_ex == bus.rt_id)) begin
        e_sif = 1'b1; e_sid = 1'b1; e_fex = 1'b1;
      end
    end
    if (Reset) begin
      e_sel = 2'd0; e_tgt = '0;
      {e_sif, e_sid, e_fid, e_fex, e_fmem, e_kill} = '0;
      p_mode = M_RUN; p_stalled = 0; p_left = 0; p_epc = '0; p_err = 1'b0;
    end
    if (chk_en) begin
      check("m.pc_sel", 32'(bus.pc_sel), 32'(e_sel));
      check("m.pc_target", bus.pc_target, e_tgt);
      check("m.stall_if", 32'(bus.stall_if), 32'(e_sif));
      check("m.stall_id", 32'(bus.stall_id), 32'(e_sid));
      check("m.flush_id", 32'(bus.flush_id), 32'(e_fid));
      check("m.flush_ex", 32'(bus.flush_ex), 32'(e_fex));
      check("m.flush_mem", 32'(bus.flush_mem), 32'(e_fmem));
      check("m.kill_wb", 32'(bus.kill_wb), 32'(e_kill));
      check("m.epc", bus.epc, m_epc);
      check("m.bus_err", 32'(bus.bus_err), 32'(m_err));
    end
  end

  always @(negedge clk) begin
    m_mode <= p_mode; m_stalled <= p_stalled; m_left <= p_left;
    m_epc  <= p_epc;  m_err     <= p_err;
  end

  task automatic clr();
    bus.Jump_mem = 0; bus.Condition_mem = 0; bus.Less_mem = 0; bus.Zero_mem = 0;
    bus.Overflow_mem = 0; bus.RegWr_mem = 0; bus.MemWr_mem = 0; bus.MemtoReg_mem = 0;
    bus.PC_Branch_mem = 0; bus.PC_Jump_mem = 0; bus.pc_mem = 0; bus.MemtoReg_ex = 0;
    bus.Rd_ex = 0; bus.rs_id = 0; bus.rt_id = 0; bus.dmem_ready = 1;
  endtask

  task automatic nxt();
    @(negedge clk); #1;
  endtask

  task automatic settle();
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish, time %0t limit 100000", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    clr(); Reset = 1'b1;
    @(negedge clk); #1; chk_en = 1'b1;
    settle();
    check("rst.pc_sel", 32'(bus.pc_sel), 0);
    check("rst.epc", bus.epc, 0);
    check("rst.bus_err", 32'(bus.bus_err), 0);
    nxt(); Reset = 1'b0; settle();
    check("idle.stall_if", 32'(bus.stall_if), 0);

    // beq taken, then reserved code never taken
    nxt(); bus.Condition_mem = 3'd1; bus.Zero_mem = 1; bus.PC_Branch_mem = 32'h40; settle();
    check("beq.pc_sel", 32'(bus.pc_sel), 1);
    check("beq.target", bus.pc_target, 32'h40);
    check("beq.flushes", 32'({bus.flush_id, bus.flush_ex, bus.flush_mem}), 32'h7);
    nxt(); bus.Condition_mem = 3'd7; bus.Less_mem = 1; settle();
    check("rsvd.pc_sel", 32'(bus.pc_sel), 0);
    check("rsvd.flush_id", 32'(bus.flush_id), 0);
    nxt(); bus.Condition_mem = 3'd4; bus.Less_mem = 0; bus.Zero_mem = 0; settle();
    check("bgtz.pc_sel", 32'(bus.pc_sel), 1);
    nxt(); bus.Condition_mem = 3'd6; bus.Less_mem = 1; settle();
    check("bgez_neg.pc_sel", 32'(bus.pc_sel), 0);
    for (int c = 0; c < 8; c++) begin
      for (int lz = 0; lz < 4; lz++) begin
        nxt(); bus.Condition_mem = 3'(c); bus.Less_mem = lz[1]; bus.Zero_mem = lz[0];
        bus.PC_Branch_mem = 32'h100 + 32'(c * 4); settle();
      end
    end

    // load-use hazard
    nxt(); clr(); bus.MemtoReg_ex = 1; bus.Rd_ex = 5; bus.rt_id = 5; bus.rs_id = 3; settle();
    check("lu.stall_if", 32'(bus.stall_if), 1);
    check("lu.flush_ex", 32'(bus.flush_ex), 1);
    check("lu.flush_id", 32'(bus.flush_id), 0);
    nxt(); bus.MemtoReg_ex = 0; settle();
    check("lu.one_cycle", 32'(bus.stall_if), 0);
    nxt(); bus.MemtoReg_ex = 1; bus.Rd_ex = 0; bus.rt_id = 0; bus.rs_id = 0; settle();
    check("lu.r0", 32'(bus.stall_id), 0);

    // overflow exception coinciding with load-use, then drain ignoring branch/overflow
    nxt(); clr(); bus.Overflow_mem = 1; bus.RegWr_mem = 1; bus.pc_mem = 32'h1234;
    bus.MemtoReg_ex = 1; bus.Rd_ex = 7; bus.rs_id = 7; settle();
    check("exc.pc_sel", 32'(bus.pc_sel), 3);
    check("exc.target", bus.pc_target, 32'h180);
    check("exc.kill_wb", 32'(bus.kill_wb), 1);
    check("exc.no_stall", 32'(bus.stall_if), 0);
    nxt(); clr(); bus.Overflow_mem = 1; bus.RegWr_mem = 1; bus.pc_mem = 32'h9999;
    bus.Condition_mem = 3'd1; bus.Zero_mem = 1; bus.PC_Branch_mem = 32'h80; settle();
    check("exc.epc", bus.epc, 32'h1234);
    check("drain1.pc_sel", 32'(bus.pc_sel), 0);
    check("drain1.flush_ex", 32'(bus.flush_ex), 1);
    nxt(); settle();
    check("drain2.flush_mem", 32'(bus.flush_mem), 1);
    check("drain2.pc_sel", 32'(bus.pc_sel), 0);
    nxt(); bus.Overflow_mem = 0; settle();
    check("post_exc.pc_sel", 32'(bus.pc_sel), 1);
    check("post_exc.target", bus.pc_target, 32'h80);

    // load waits 3 cycles with a jump behind it
    nxt(); clr(); bus.MemtoReg_mem = 1; bus.dmem_ready = 0; bus.Jump_mem = 1;
    bus.PC_Jump_mem = 32'h2000; settle();
    for (int i = 0; i < 3; i++) begin
      if (i != 0) begin nxt(); settle(); end
      check("mw.stall_if", 32'(bus.stall_if), 1);
      check("mw.pc_sel", 32'(bus.pc_sel), 0);
      check("mw.flush_mem", 32'(bus.flush_mem), 0);
    end
    nxt(); bus.dmem_ready = 1; settle();
    check("mw.jump_sel", 32'(bus.pc_sel), 2);
    check("mw.jump_tgt", bus.pc_target, 32'h2000);
    check("mw.stall_rel", 32'(bus.stall_if), 0);

    // memory never answers: 15 stalled cycles, then forced release and sticky bus_err
    nxt(); clr(); bus.MemWr_mem = 1; bus.dmem_ready = 0; settle();
    check("tmo.stall1", 32'(bus.stall_if), 1);
    for (int k = 2; k <= 15; k++) begin
      nxt(); settle();
      check("tmo.stall", 32'(bus.stall_if), 1);
      check("tmo.err_low", 32'(bus.bus_err), 0);
    end
    nxt(); settle();
    check("tmo.release", 32'(bus.stall_if), 0);
    nxt(); clr(); settle();
    check("tmo.bus_err", 32'(bus.bus_err), 1);
    nxt(); nxt(); settle();
    check("tmo.sticky", 32'(bus.bus_err), 1);

    // reset in the middle of an exception drain
    nxt(); bus.Overflow_mem = 1; bus.RegWr_mem = 1; bus.pc_mem = 32'h55; settle();
    check("rexc.pc_sel", 32'(bus.pc_sel), 3);
    nxt(); clr(); Reset = 1'b1; settle();
    check("rexc.gated", 32'(bus.flush_id), 0);
    nxt(); Reset = 1'b0; settle();
    check("rexc.pc_sel", 32'(bus.pc_sel), 0);
    check("rexc.flush_id", 32'(bus.flush_id), 0);
    check("rexc.epc", bus.epc, 0);
    check("rexc.bus_err", 32'(bus.bus_err), 0);
    nxt(); settle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
